// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture: receiving end of an 8x8 RGB LED row-scan interface.
// Synchronises the scan stream, samples each row once it is stable, and builds
// frames in a double-buffered 8x24-bit store with a registered read port.
// Ports:
//   CLK, RST             clock, asynchronous active-high reset
//   DATA_R/G/B[7:0]      column data of the row currently being scanned
//   A_count[3:0]         bit3 = scan enable, bits[2:0] = row index
//   rd_row[2:0]          front-buffer row to read
//   rd_data[23:0]        {R,G,B} of rd_row, lit = 1, one-cycle latency
//   frame_done           one-cycle pulse while a frame is being committed
//   frame_cnt[7:0]       committed frame count (wraps)
//   scan_stall           no row sampled for TIMEOUT cycles
//   seq_err              sticky out-of-order row flag
module matrix_scan_capture #(
  parameter int SETTLE     = 4,
  parameter int TIMEOUT    = 200000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_R,
  input  logic [7:0]  DATA_G,
  input  logic [7:0]  DATA_B,
  input  logic [3:0]  A_count,
  input  logic [2:0]  rd_row,
  output logic [23:0] rd_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        scan_stall,
  output logic        seq_err
);

  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      SETTLE_V  = 8'(SETTLE);
  localparam logic [7:0]      SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [TW-1:0]   TMO_V     = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_COMMIT  = 2'd2,
    S_STALL   = 2'd3
  } state_t;

  // {A_count, R, G, B}: two synchroniser stages plus one delayed copy for
  // change detection on the synchronised stream.
  logic [27:0]   in_s1_q, in_s1_d;
  logic [27:0]   in_s2_q, in_s2_d;
  logic [27:0]   in_prev_q, in_prev_d;

  logic [7:0]    settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    seen_q, seen_d;
  logic [2:0]    last_row_q, last_row_d;
  logic          seq_err_q, seq_err_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [23:0]   rd_data_q, rd_data_d;
  logic [23:0]   front_q [8];
  logic [23:0]   front_d [8];
  logic [23:0]   back_q  [8];
  logic [23:0]   back_d  [8];
  state_t        state_q, state_d;

  logic          scan_en;
  logic [2:0]    cur_row;
  logic [23:0]   cur_rgb;
  logic [23:0]   cap_val;
  logic          change;
  logic          sample;
  logic          stall_now;
  logic          commit;
  logic [7:0]    row_bit;
  logic [7:0]    seen_base;

  assign scan_en   = in_s2_q[27];
  assign cur_row   = in_s2_q[26:24];
  assign cur_rgb   = in_s2_q[23:0];
  assign cap_val   = ACTIVE_LOW ? ~cur_rgb : cur_rgb;
  assign change    = (in_s2_q != in_prev_q);
  // Fires on the single cycle the settle counter steps onto SETTLE; once
  // saturated it cannot fire again until the stream changes.
  assign sample    = scan_en && !change && (settle_q == SETTLE_M1);
  assign stall_now = (tmo_q == TMO_V);
  assign commit    = (state_q == S_COMMIT);
  assign row_bit   = 8'd1 << cur_row;
  // The commit and a stall both start a fresh frame; a sample in that same
  // cycle lands on top of the cleared mask.
  assign seen_base = (commit || state_q == S_STALL) ? 8'd0 : seen_q;

  // Datapath next-state
  always_comb begin
    in_s1_d     = {A_count, DATA_R, DATA_G, DATA_B};
    in_s2_d     = in_s1_q;
    in_prev_d   = in_s2_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    seen_d      = seen_base;
    last_row_d  = last_row_q;
    seq_err_d   = seq_err_q;
    frame_cnt_d = frame_cnt_q;
    front_d     = front_q;
    back_d      = back_q;
    rd_data_d   = front_q[rd_row];

    if (!scan_en || change) begin
      settle_d = 8'd0;
    end else if (settle_q != SETTLE_V) begin
      settle_d = settle_q + 8'd1;
    end

    if (sample) begin
      tmo_d = '0;
    end else if (!stall_now) begin
      tmo_d = tmo_q + 1'b1;
    end

    // Front copy reads back_q, so a same-cycle sample goes only into the
    // back buffer for the next frame.
    if (commit) begin
      front_d     = back_q;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if (sample) begin
      back_d[cur_row] = cap_val;
      last_row_d      = cur_row;
      // First row after a stall restarts the sequence without flagging it.
      if (state_q == S_STALL || cur_row == last_row_q ||
          cur_row == last_row_q + 3'd1) begin
        seen_d = seen_base | row_bit;
      end else begin
        seen_d    = row_bit;
        seq_err_d = 1'b1;
      end
    end
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    if (sample) begin
      state_d = (seen_d == 8'hFF) ? S_COMMIT : S_CAPTURE;
    end else if (stall_now) begin
      state_d = S_STALL;
    end else if (commit) begin
      state_d = S_IDLE;
    end
  end

  // FSM outputs
  always_comb begin
    frame_done = (state_q == S_COMMIT);
  end

  assign rd_data    = rd_data_q;
  assign frame_cnt  = frame_cnt_q;
  assign scan_stall = stall_now;
  assign seq_err    = seq_err_q;

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_s1_q     <= '0;
      in_s2_q     <= '0;
      in_prev_q   <= '0;
      settle_q    <= '0;
      tmo_q       <= '0;
      seen_q      <= '0;
      last_row_q  <= 3'd7;
      seq_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      rd_data_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        front_q[i] <= '0;
        back_q[i]  <= '0;
      end
    end else begin
      in_s1_q     <= in_s1_d;
      in_s2_q     <= in_s2_d;
      in_prev_q   <= in_prev_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
      seen_q      <= seen_d;
      last_row_q  <= last_row_d;
      seq_err_q   <= seq_err_d;
      frame_cnt_q <= frame_cnt_d;
      rd_data_q   <= rd_data_d;
      for (int i = 0; i < 8; i++) begin
        front_q[i] <= front_d[i];
        back_q[i]  <= back_d[i];
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Directed bench for matrix_scan_capture with a short TIMEOUT.
module tb_matrix_scan_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 300;
  localparam int HOLD    = SETTLE + 10;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  DATA_R = 8'hFF;
  logic [7:0]  DATA_G = 8'hFF;
  logic [7:0]  DATA_B = 8'hFF;
  logic [3:0]  A_count = 4'd0;
  logic [2:0]  rd_row = 3'd0;
  logic [23:0] rd_data;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        scan_stall;
  logic        seq_err;

  int n_vec  = 0;
  int n_bad  = 0;
  int fd_cnt = 0;

  matrix_scan_capture #(
    .SETTLE    (SETTLE),
    .TIMEOUT   (TIMEOUT),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_R    (DATA_R),
    .DATA_G    (DATA_G),
    .DATA_B    (DATA_B),
    .A_count   (A_count),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt),
    .scan_stall(scan_stall),
    .seq_err   (seq_err)
  );

  always #5 CLK = ~CLK;

  // Counts cycles in which frame_done was high before the edge.
  always @(posedge CLK) begin
    if (frame_done === 1'b1) fd_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] row, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b, input int cyc);
    A_count = {en, row};
    DATA_R  = r;
    DATA_G  = g;
    DATA_B  = b;
    repeat (cyc) @(negedge CLK);
  endtask

  task automatic scan_row(input logic [2:0] row, input logic [7:0] r);
    drive(1'b1, row, r, 8'hFF, 8'hFF, HOLD);
  endtask

  // Pattern frame: R = A0^row, G = 5C, B = FF -> stored {~R, A3, 00}.
  task automatic run_frame();
    for (int r = 0; r < 8; r++) begin
      drive(1'b1, 3'(r), 8'hA0 ^ {5'd0, 3'(r)}, 8'h5C, 8'hFF, HOLD);
    end
  endtask

  task automatic read_row(input logic [2:0] row, output logic [23:0] val);
    rd_row = row;
    @(negedge CLK);
    @(negedge CLK);
    val = rd_data;
  endtask

  task automatic do_reset();
    A_count = 4'd0;
    DATA_R  = 8'hFF;
    DATA_G  = 8'hFF;
    DATA_B  = 8'hFF;
    RST     = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    logic [23:0] v;
    logic [23:0] rd_hist [21];
    int          fd0;
    int          lat;
    int          seq3 [14];

    // ---- reset state
    @(negedge CLK);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_stall", scan_stall, 0);
    chk("rst_seq_err", seq_err, 0);
    do_reset();

    // ---- 1: single frame, one lit red pixel on row 3
    fd0 = fd_cnt;
    for (int r = 0; r < 7; r++) scan_row(3'(r), (r == 3) ? 8'hFE : 8'hFF);
    chk("t1_no_early_commit", fd_cnt - fd0, 0);
    rd_row  = 3'd3;
    A_count = 4'b1111;
    DATA_R  = 8'hFF;
    lat     = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      rd_hist[i] = rd_data;
      if (frame_done && lat == 0) lat = i;
    end
    chk("t1_done_latency", lat, 7);
    chk("t1_rd_in_commit", rd_hist[8], 24'h000000);
    chk("t1_rd_after_commit", rd_hist[9], 24'h010000);
    chk("t1_one_pulse", fd_cnt - fd0, 1);
    chk("t1_frame_cnt", frame_cnt, 1);
    read_row(3'd3, v); chk("t1_row3", v, 24'h010000);
    read_row(3'd0, v); chk("t1_row0", v, 24'h000000);
    read_row(3'd7, v); chk("t1_row7", v, 24'h000000);
    chk("t1_seq_err", seq_err, 0);

    // ---- 2: glitching data on row 2, only the final stable value lands
    do_reset();
    fd0 = fd_cnt;
    scan_row(3'd0, 8'hFF);
    scan_row(3'd1, 8'hFF);
    for (int i = 0; i < SETTLE - 1; i++) begin
      drive(1'b1, 3'd2, (i % 2 == 1) ? 8'h00 : 8'h0F, 8'hFF, 8'hFF, 1);
    end
    drive(1'b1, 3'd2, 8'h3C, 8'hFF, 8'hFF, HOLD);
    for (int r = 3; r < 8; r++) scan_row(3'(r), 8'hFF);
    chk("t2_one_frame", fd_cnt - fd0, 1);
    chk("t2_seq_err", seq_err, 0);
    read_row(3'd2, v); chk("t2_row2", v, 24'hC30000);

    // ---- 3: out-of-order rows restart the frame
    do_reset();
    fd0  = fd_cnt;
    seq3 = '{0, 1, 2, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
    for (int i = 0; i < 14; i++) begin
      scan_row(3'(seq3[i]), 8'hFF);
      if (i == 9)  chk("t3_no_commit_before_4", fd_cnt - fd0, 0);
      if (i == 10) chk("t3_commit_after_4", fd_cnt - fd0, 1);
    end
    chk("t3_one_frame_total", fd_cnt - fd0, 1);
    chk("t3_seq_err", seq_err, 1);

    // ---- 4: stall mid-frame, resume at row 4
    do_reset();
    fd0 = fd_cnt;
    for (int r = 0; r < 4; r++) scan_row(3'(r), 8'hFF);
    repeat (TIMEOUT - 20) @(negedge CLK);
    chk("t4_stall_not_yet", scan_stall, 0);
    repeat (25) @(negedge CLK);
    chk("t4_stall_set", scan_stall, 1);
    scan_row(3'd4, 8'hFF);
    chk("t4_stall_cleared", scan_stall, 0);
    chk("t4_seq_err_clear", seq_err, 0);
    for (int r = 5; r < 8; r++) scan_row(3'(r), 8'hFF);
    chk("t4_no_stale_commit", fd_cnt - fd0, 0);
    for (int r = 0; r < 4; r++) scan_row(3'(r), 8'hFF);
    chk("t4_fresh_commit", fd_cnt - fd0, 1);
    chk("t4_seq_err_end", seq_err, 0);

    // ---- 5: scan enable low, nothing sampled, stall after TIMEOUT
    do_reset();
    fd0 = fd_cnt;
    for (int i = 0; i < 40; i++) drive(1'b0, 3'(i % 8), 8'h00, 8'h00, 8'h00, 10);
    chk("t5_no_frame", fd_cnt - fd0, 0);
    chk("t5_stall", scan_stall, 1);
    chk("t5_frame_cnt", frame_cnt, 0);
    read_row(3'd0, v); chk("t5_row0", v, 24'h000000);

    // ---- 6: reset during frame 3, then frame counter wrap
    do_reset();
    run_frame();
    run_frame();
    for (int r = 0; r < 5; r++) drive(1'b1, 3'(r), 8'hA0 ^ {5'd0, 3'(r)}, 8'h5C, 8'hFF, HOLD);
    rd_row = 3'd5;
    drive(1'b1, 3'd5, 8'hA5, 8'h5C, 8'hFF, 3);
    chk("t6_pre_cnt", frame_cnt, 2);
    chk("t6_pre_rd", rd_data, 24'h5AA300);
    #2;
    RST     = 1'b1;
    A_count = 4'd0;
    #1;
    chk("t6_rst_rd", rd_data, 0);
    chk("t6_rst_cnt", frame_cnt, 0);
    chk("t6_rst_done", frame_done, 0);
    chk("t6_rst_stall", scan_stall, 0);
    chk("t6_rst_seq", seq_err, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    read_row(3'd5, v); chk("t6_row5_cleared", v, 24'h000000);
    read_row(3'd0, v); chk("t6_row0_cleared", v, 24'h000000);
    fd0 = fd_cnt;
    run_frame();
    chk("t6_cnt_one", frame_cnt, 1);
    read_row(3'd5, v); chk("t6_row5_new", v, 24'h5AA300);
    read_row(3'd0, v); chk("t6_row0_new", v, 24'h5FA300);
    for (int f = 0; f < 254; f++) run_frame();
    chk("t6_cnt_255", frame_cnt, 255);
    run_frame();
    chk("t6_cnt_wrap", frame_cnt, 0);
    chk("t6_pulses", fd_cnt - fd0, 256);
    chk("t6_seq_err", seq_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
